dac8563_frame_rx: RTL and testbench
===================================

DAC8563_FRAME_RX -- requirements
Module: dac8563_frame_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops per serial input (legal 2..3).
REQ-002 SHALL have port SYS_CLK  input  1  sole clock.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port SYNC  input  1  frame select, active-low, asynchronous to SYS_CLK.
REQ-005 SHALL have port SCLK  input  1  serial clock, asynchronous to SYS_CLK.
REQ-006 SHALL have port MOSI  input  1  serial data, MSB first.
REQ-007 SHALL have port FRAME_VALID  output  1  one-cycle pulse on each completed 24-bit frame.
REQ-008 SHALL have port FRAME_ERR  output  1  one-cycle pulse on each aborted frame.
REQ-009 SHALL have port CMD  output  3  frame bits [21:19] of the last valid frame.
REQ-010 SHALL have port ADDR  output  3  frame bits [18:16] of the last valid frame.
REQ-011 SHALL have port DATA  output  16  frame bits [15:0] of the last valid frame.
REQ-012 SHALL have port DAC_A  output  16  modelled channel A DAC register.
REQ-013 SHALL have port DAC_B  output  16  modelled channel B DAC register.

Function
REQ-014 SHALL pass SYNC, SCLK and MOSI through SYNC_STAGES flops, then one edge-detect register; all logic uses the synchronized copies only.
REQ-015 SHALL support SCLK frequencies up to SYS_CLK/4; higher rates are out of scope.
REQ-016 SHALL implement states IDLE, SHIFT and HOLD.
REQ-017 IDLE -> SHIFT on the synchronized SYNC falling edge; clear the bit counter and the 24-bit shift register.
REQ-018 In SHIFT, SHALL sample MOSI on each synchronized SCLK falling edge, shift it in MSB first, and increment a 5-bit counter.
REQ-019 On the 24th falling edge SHALL commit the frame, pulse FRAME_VALID, load CMD/ADDR/DATA, and go SHIFT -> HOLD.
REQ-020 FRAME_VALID SHALL assert within SYNC_STAGES+2 SYS_CLK cycles of the 24th SCLK falling edge at the pin.
REQ-021 In SHIFT, a synchronized SYNC rising edge with counter <24 SHALL pulse FRAME_ERR, discard the frame, leave all registers unchanged, and go -> IDLE.
REQ-022 In HOLD, further SCLK edges SHALL be ignored; SYNC rising -> IDLE with no pulse.
REQ-023 If the SYNC rising edge and the 24th SCLK falling edge are detected in the same cycle, SHALL treat the frame as complete (FRAME_VALID, not FRAME_ERR).
REQ-024 SCLK edges while in IDLE SHALL be ignored.
REQ-025 Frame bits [23:22] SHALL be don't-care.
REQ-026 Channel mapping: ADDR 000 -> A, 001 -> B, 111 -> both; any other ADDR updates no channel.
REQ-027 CMD 011 (write and update) SHALL load DATA into the DAC register of each selected channel, in the cycle FRAME_VALID is high, visible the next cycle.
REQ-028 CMD 000 (write input) SHALL load DATA into the per-channel input register only.
REQ-029 CMD 010 (update) SHALL copy the input register into the DAC register for each selected channel.
REQ-030 All other CMD values SHALL still pulse FRAME_VALID and load CMD/ADDR/DATA, and SHALL NOT change the input or DAC registers.
REQ-031 FRAME_VALID and FRAME_ERR SHALL never assert in the same cycle.

Reset
REQ-032 On RST high, SHALL asynchronously force state IDLE, counter 0, shift register 0, synchronizers to idle level (SYNC=1, SCLK=1, MOSI=0), FRAME_VALID=0, FRAME_ERR=0, CMD=0, ADDR=0, DATA=0.
REQ-033 On RST high, SHALL force DAC_A, DAC_B and both input registers to 16'h8000 (midscale).
REQ-034 Reset mid-frame SHALL discard the partial frame without a FRAME_ERR pulse.
REQ-035 After RST falls, the first frame SHALL begin only on a new SYNC falling edge; a SYNC that is already low SHALL NOT start a frame.

Verification
REQ-036 Frame 0x18FFFF at SCLK = SYS_CLK/4 -> one FRAME_VALID, CMD=3, ADDR=0, DATA=FFFF, DAC_A=FFFF, DAC_B=8000.
REQ-037 Frame 0x1F1234 -> DAC_A=DAC_B=1234.
REQ-038 Frame 0x010ABC then 0x110000 -> after the first frame DAC_B=8000; after the second, DAC_B=0ABC and DAC_A is unchanged.
REQ-039 SYNC raised after 10 SCLK falling edges -> FRAME_ERR pulse, no FRAME_VALID, all registers unchanged; the next full frame decodes correctly.
REQ-040 Frame of 30 SCLK edges, data 0x18AAAA followed by 6 extra bits -> DAC_A=AAAA, with a single FRAME_VALID pulse.
REQ-041 RST asserted after 12 bits, then released, then frame 0x180001 -> no FRAME_ERR, DAC_A=8000 before the frame and 0001 after it.

Source files
------------

// File: rtl/dac8563_frame_rx.sv
// dac8563_frame_rx
// Receives DAC8563-style 24-bit SPI frames on an asynchronous SYNC/SCLK/MOSI
// bus, decodes CMD/ADDR/DATA and models the two channel input and DAC
// registers. All serial inputs are resynchronized into SYS_CLK before use.
module dac8563_frame_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        SYS_CLK,
    input  logic        RST,
    input  logic        SYNC,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        FRAME_VALID,
    output logic        FRAME_ERR,
    output logic [2:0]  CMD,
    output logic [2:0]  ADDR,
    output logic [15:0] DATA,
    output logic [15:0] DAC_A,
    output logic [15:0] DAC_B
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [15:0] MIDSCALE = 16'h8000;

    logic [SYNC_STAGES-1:0] sync_sr;
    logic [SYNC_STAGES-1:0] sclk_sr;
    logic [SYNC_STAGES-1:0] mosi_sr;
    logic                   sync_d;
    logic                   sclk_d;
    logic [SYNC_STAGES:0]   arm_sr;

    logic sync_s;
    logic sclk_s;
    logic mosi_s;
    logic armed;
    logic sync_fall;
    logic sync_rise;
    logic sclk_fall;

    state_t      state;
    logic [4:0]  bit_cnt;
    logic [23:0] shreg;
    logic [23:0] shreg_next;

    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        sel_a;
    logic        sel_b;

    assign sync_s = sync_sr[SYNC_STAGES-1];
    assign sclk_s = sclk_sr[SYNC_STAGES-1];
    assign mosi_s = mosi_sr[SYNC_STAGES-1];

    // The arm chain keeps the reset-forced SYNC=1 from turning an already-low
    // SYNC into a fake falling edge while the synchronizer refills.
    assign armed     = arm_sr[SYNC_STAGES];
    assign sync_fall = armed & sync_d & ~sync_s;
    assign sync_rise = ~sync_d & sync_s;
    assign sclk_fall = sclk_d & ~sclk_s;

    // MOSI is taken from the same synchronizer depth as SCLK so the sampled
    // bit lines up with the detected falling edge.
    assign shreg_next = {shreg[22:0], mosi_s};

    assign sel_a = (ADDR == 3'b000) || (ADDR == 3'b111);
    assign sel_b = (ADDR == 3'b001) || (ADDR == 3'b111);

    // Synchronizer chains, edge-detect registers and post-reset arm chain.
    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            sync_sr <= '1;
            sclk_sr <= '1;
            mosi_sr <= '0;
            sync_d  <= 1'b1;
            sclk_d  <= 1'b1;
            arm_sr  <= '0;
        end else begin
            sync_sr <= {sync_sr[SYNC_STAGES-2:0], SYNC};
            sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], SCLK};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], MOSI};
            sync_d  <= sync_s;
            sclk_d  <= sclk_s;
            arm_sr  <= {arm_sr[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Frame FSM: shift bits in, commit on the 24th edge, flag aborted frames.
    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            bit_cnt     <= 5'd0;
            shreg       <= 24'd0;
            FRAME_VALID <= 1'b0;
            FRAME_ERR   <= 1'b0;
            CMD         <= 3'd0;
            ADDR        <= 3'd0;
            DATA        <= 16'd0;
        end else begin
            FRAME_VALID <= 1'b0;
            FRAME_ERR   <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync_fall) begin
                        state   <= SHIFT;
                        bit_cnt <= 5'd0;
                        shreg   <= 24'd0;
                    end
                end
                SHIFT: begin
                    if (sclk_fall) begin
                        shreg   <= shreg_next;
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                    if (sclk_fall && (bit_cnt == 5'd23)) begin
                        // A completing edge wins over a simultaneous SYNC rise;
                        // in that case skip HOLD since the rise is already consumed.
                        FRAME_VALID <= 1'b1;
                        CMD         <= shreg_next[21:19];
                        ADDR        <= shreg_next[18:16];
                        DATA        <= shreg_next[15:0];
                        state       <= sync_rise ? IDLE : HOLD;
                    end else if (sync_rise) begin
                        FRAME_ERR <= 1'b1;
                        state     <= IDLE;
                    end
                end
                HOLD: begin
                    if (sync_rise) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Channel register model, updated the cycle after a committed frame.
    // Write-and-update loads only the DAC register; the input register keeps
    // whatever the last write-input command left there.
    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            in_a  <= MIDSCALE;
            in_b  <= MIDSCALE;
            DAC_A <= MIDSCALE;
            DAC_B <= MIDSCALE;
        end else if (FRAME_VALID) begin
            case (CMD)
                3'b011: begin
                    if (sel_a) DAC_A <= DATA;
                    if (sel_b) DAC_B <= DATA;
                end
                3'b000: begin
                    if (sel_a) in_a <= DATA;
                    if (sel_b) in_b <= DATA;
                end
                3'b010: begin
                    if (sel_a) DAC_A <= in_a;
                    if (sel_b) DAC_B <= in_b;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dac8563_frame_rx.sv
// Testbench for dac8563_frame_rx: directed frames plus randomized frames,
// compared against a frame-level model of the channel registers.
`timescale 1ns/1ps
module tb_dac8563_frame_rx;

    logic        SYS_CLK = 1'b0;
    logic        RST;
    logic        SYNC;
    logic        SCLK;
    logic        MOSI;
    logic        FRAME_VALID;
    logic        FRAME_ERR;
    logic [2:0]  CMD;
    logic [2:0]  ADDR;
    logic [15:0] DATA;
    logic [15:0] DAC_A;
    logic [15:0] DAC_B;

    dac8563_frame_rx #(.SYNC_STAGES(2)) dut (
        .SYS_CLK     (SYS_CLK),
        .RST         (RST),
        .SYNC        (SYNC),
        .SCLK        (SCLK),
        .MOSI        (MOSI),
        .FRAME_VALID (FRAME_VALID),
        .FRAME_ERR   (FRAME_ERR),
        .CMD         (CMD),
        .ADDR        (ADDR),
        .DATA        (DATA),
        .DAC_A       (DAC_A),
        .DAC_B       (DAC_B)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int n_vec = 0;
    int n_bad = 0;
    int vcnt = 0;
    int ecnt = 0;
    int both_cnt = 0;

    // Pulse counters sampled away from the active edge.
    always @(negedge SYS_CLK) begin
        if (FRAME_VALID === 1'b1) vcnt++;
        if (FRAME_ERR === 1'b1) ecnt++;
        if (FRAME_VALID === 1'b1 && FRAME_ERR === 1'b1) both_cnt++;
    end

    // Frame-level reference state.
    logic [2:0]  m_cmd, m_addr;
    logic [15:0] m_data, m_in_a, m_in_b, m_dac_a, m_dac_b;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cmd = 3'd0; m_addr = 3'd0; m_data = 16'd0;
        m_in_a = 16'h8000; m_in_b = 16'h8000;
        m_dac_a = 16'h8000; m_dac_b = 16'h8000;
    endtask

    task automatic model_commit(input logic [23:0] f);
        bit a, b;
        m_cmd  = f[21:19];
        m_addr = f[18:16];
        m_data = f[15:0];
        a = (m_addr == 3'd0) || (m_addr == 3'd7);
        b = (m_addr == 3'd1) || (m_addr == 3'd7);
        case (m_cmd)
            3'd3: begin if (a) m_dac_a = m_data; if (b) m_dac_b = m_data; end
            3'd0: begin if (a) m_in_a = m_data;  if (b) m_in_b = m_data;  end
            3'd2: begin if (a) m_dac_a = m_in_a; if (b) m_dac_b = m_in_b; end
            default: ;
        endcase
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_cmd"},   CMD,   m_cmd);
        chk({tag, "_addr"},  ADDR,  m_addr);
        chk({tag, "_data"},  DATA,  m_data);
        chk({tag, "_dac_a"}, DAC_A, m_dac_a);
        chk({tag, "_dac_b"}, DAC_B, m_dac_b);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #30;
        RST = 1'b0;
        model_reset();
        #60;
    endtask

    // n SCLK falling edges, frame bits MSB first, then random filler bits.
    // tie=1 raises SYNC at the very instant of the last falling edge.
    task automatic send(input logic [23:0] f, input int n, input bit tie, input int hp);
        SYNC = 1'b0;
        for (int i = 0; i < n; i++) begin
            MOSI = (i < 24) ? f[23-i] : 1'($urandom);
            #(hp);
            SCLK = 1'b0;
            if (tie && i == n - 1) SYNC = 1'b1;
            #(hp);
            SCLK = 1'b1;
        end
        #(hp);
        SYNC = 1'b1;
        #200;
    endtask

    task automatic run_frame(input string tag, input logic [23:0] f, input int n,
                             input bit tie, input int hp);
        int v0, e0;
        v0 = vcnt;
        e0 = ecnt;
        send(f, n, tie, hp);
        chk({tag, "_valid"}, vcnt - v0, (n >= 24) ? 1 : 0);
        chk({tag, "_err"},   ecnt - e0, (n >= 24) ? 0 : 1);
        if (n >= 24) model_commit(f);
        chk_regs(tag);
    endtask

    initial begin
        int v0, e0;
        RST = 1'b1; SYNC = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
        model_reset();
        #1;
        // Reset values, checked while reset is held.
        #20;
        chk("rst_valid", FRAME_VALID, 0);
        chk("rst_err",   FRAME_ERR,   0);
        chk_regs("rst");
        do_reset();

        run_frame("f18ffff", 24'h18FFFF, 24, 1'b0, 20);
        chk("f18ffff_lit_a", DAC_A, 16'hFFFF);
        chk("f18ffff_lit_b", DAC_B, 16'h8000);

        run_frame("f1f1234", 24'h1F1234, 24, 1'b0, 20);
        chk("f1f1234_lit_b", DAC_B, 16'h1234);

        run_frame("f010abc", 24'h010ABC, 24, 1'b0, 30);
        chk("f010abc_lit_b", DAC_B, 16'h1234);
        run_frame("f110000", 24'h110000, 24, 1'b0, 20);
        chk("f110000_lit_b", DAC_B, 16'h0ABC);
        chk("f110000_lit_a", DAC_A, 16'h1234);

        run_frame("abort10", 24'h185555, 10, 1'b0, 30);
        run_frame("after_abort", 24'h180777, 24, 1'b0, 20);

        run_frame("long30", 24'h18AAAA, 30, 1'b0, 20);
        chk("long30_lit_a", DAC_A, 16'hAAAA);

        run_frame("tie", 24'h190042, 24, 1'b1, 20);
        run_frame("after_tie", 24'h1F0099, 24, 1'b0, 20);

        // Reset in the middle of a frame: no error, registers back to midscale.
        v0 = vcnt; e0 = ecnt;
        SYNC = 1'b0;
        for (int i = 0; i < 12; i++) begin
            MOSI = 1'($urandom);
            #20; SCLK = 1'b0;
            #20; SCLK = 1'b1;
        end
        RST = 1'b1;
        #30;
        chk("midrst_dac_a", DAC_A, 16'h8000);
        RST = 1'b0;
        SYNC = 1'b1;
        model_reset();
        #100;
        chk("midrst_err",   ecnt - e0, 0);
        chk("midrst_valid", vcnt - v0, 0);
        run_frame("f180001", 24'h180001, 24, 1'b0, 20);
        chk("f180001_lit_a", DAC_A, 16'h0001);

        // SYNC already low at reset release must not open a frame.
        SYNC = 1'b0;
        RST = 1'b1;
        #30;
        RST = 1'b0;
        model_reset();
        v0 = vcnt; e0 = ecnt;
        #100;
        for (int i = 0; i < 24; i++) begin
            MOSI = (i % 3) == 0;
            #20; SCLK = 1'b0;
            #20; SCLK = 1'b1;
        end
        #20;
        SYNC = 1'b1;
        #200;
        chk("lowsync_valid", vcnt - v0, 0);
        chk("lowsync_err",   ecnt - e0, 0);
        chk_regs("lowsync");

        // Randomized frames biased toward the decoded commands and addresses.
        for (int k = 0; k < 40; k++) begin
            logic [23:0] f;
            logic [2:0]  c, a;
            int          n, sel;
            bit          tie;
            f = 24'($urandom);
            sel = $urandom_range(0, 4);
            c = (sel == 0) ? 3'd0 : (sel == 1) ? 3'd2 : (sel == 2) ? 3'd3 : 3'($urandom);
            sel = $urandom_range(0, 4);
            a = (sel == 0) ? 3'd0 : (sel == 1) ? 3'd1 : (sel == 2) ? 3'd7 : 3'($urandom);
            f[21:19] = c;
            f[18:16] = a;
            sel = $urandom_range(0, 9);
            tie = 1'b0;
            if (sel == 0)      n = $urandom_range(0, 23);
            else if (sel == 1) n = $urandom_range(25, 30);
            else if (sel == 2) begin n = 24; tie = 1'b1; end
            else               n = 24;
            run_frame("rand", f, n, tie, 10 * $urandom_range(2, 4));
        end

        chk("overlap", both_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
